// File: rtl/mure_block_packer_if.sv
// Commit-side and encoder-side bundles for the multiple-retirement block packer.
// The commit master drives retired lanes; the block master presents closed blocks.
interface mure_commit_if #(
  parameter int NRET      = 2,
  parameter int XLEN      = 64,
  parameter int ITYPE_LEN = 3,
  parameter int CAUSE_LEN = 8,
  parameter int PRIV_LEN  = 2
);
  logic [NRET-1:0]                valid;
  logic [NRET-1:0][XLEN-1:0]      pc;
  logic [NRET-1:0][ITYPE_LEN-1:0] itype;
  logic [NRET-1:0]                compressed;
  logic [PRIV_LEN-1:0]            priv;
  logic [CAUSE_LEN-1:0]           cause;
  logic [XLEN-1:0]                tval;
  logic                           ready;

  modport master (output valid, pc, itype, compressed, priv, cause, tval, input ready);
  modport slave  (input valid, pc, itype, compressed, priv, cause, tval, output ready);
endinterface

interface mure_block_if #(
  parameter int N           = 2,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 8,
  parameter int PRIV_LEN    = 2
);
  logic [N-1:0]                  valid;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire;
  logic [N-1:0]                  ilastsize;
  logic [N-1:0][ITYPE_LEN-1:0]   itype;
  logic [N-1:0][XLEN-1:0]        iaddr;
  logic [N-1:0][PRIV_LEN-1:0]    priv;
  logic [N-1:0][CAUSE_LEN-1:0]   cause;
  logic [N-1:0][XLEN-1:0]        tval;
  logic                          ready;

  modport master (output valid, iretire, ilastsize, itype, iaddr, priv, cause, tval, input ready);
  modport slave  (input valid, iretire, ilastsize, itype, iaddr, priv, cause, tval, output ready);
endinterface

// File: rtl/mure_block_packer.sv
// Packs up to NRET retired instructions per cycle into E-Trace instruction blocks,
// queues closed blocks in a multi-push FIFO and presents up to N of them per cycle.
module mure_block_packer #(
  parameter int NRET        = 2,
  parameter int N           = 2,
  parameter int DEPTH       = 8,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 8,
  parameter int PRIV_LEN    = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mure_commit_if.slave commit,
  mure_block_if.master blocks,
  output logic         overflow_o
);

  localparam int NPUSH = NRET + 1;
  localparam int PN_W  = $clog2(NPUSH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [IRETIRE_LEN:0] CNT_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } block_t;

  function automatic block_t make_block(
    input logic [IRETIRE_LEN-1:0] cnt,
    input logic                   lsize,
    input logic [ITYPE_LEN-1:0]   it,
    input logic [XLEN-1:0]        addr,
    input logic [PRIV_LEN-1:0]    pv,
    input logic [CAUSE_LEN-1:0]   cs,
    input logic [XLEN-1:0]        tv
  );
    block_t b;
    b.iretire   = cnt;
    b.ilastsize = lsize;
    b.itype     = it;
    b.iaddr     = addr;
    b.priv      = pv;
    b.cause     = cs;
    b.tval      = tv;
    return b;
  endfunction

  logic                   open_q, open_d;
  logic [IRETIRE_LEN-1:0] count_q, count_d;
  logic [XLEN-1:0]        start_q, start_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;
  logic                   lsize_q, lsize_d;
  logic                   overflow_q;

  block_t                 mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]       occ_q, out_n, pop_n;

  block_t                 push_blk [NPUSH];
  logic [PN_W-1:0]        push_n, push_acc;
  logic                   stop;
  logic [1:0]             sz;
  logic                   accept, in_present;

  // Readiness depends on registered occupancy only, so a full cycle's worth of closes always fits.
  assign accept       = occ_q <= OCC_W'(DEPTH - NPUSH);
  assign commit.ready = accept;
  assign overflow_o   = overflow_q;
  assign push_acc     = accept ? push_n : '0;

  always_comb begin
    in_present = |commit.valid;
    for (int i = 0; i < NRET; i++) begin
      if (commit.itype[i] == ITYPE_LEN'(1) || commit.itype[i] == ITYPE_LEN'(2)) in_present = 1'b1;
    end
  end

  // Lane-by-lane chain over the open block; every close is appended to push_blk in order.
  always_comb begin
    open_d  = open_q;
    count_d = count_q;
    start_d = start_q;
    priv_d  = priv_q;
    lsize_d = lsize_q;
    push_n  = '0;
    stop    = 1'b0;
    sz      = '0;
    for (int k = 0; k < NPUSH; k++) push_blk[k] = '0;

    if (open_d && commit.priv != priv_d) begin
      push_blk[0] = make_block(count_d, lsize_d, '0, start_d, priv_d, '0, '0);
      push_n      = PN_W'(1);
      open_d      = 1'b0;
    end

    for (int i = 0; i < NRET; i++) begin
      if (!stop) begin
        if (commit.itype[i] == ITYPE_LEN'(1) || commit.itype[i] == ITYPE_LEN'(2)) begin
          if (push_n < PN_W'(NPUSH)) begin
            push_blk[push_n] = open_d
              ? make_block(count_d, lsize_d, commit.itype[i], start_d, priv_d, commit.cause, commit.tval)
              : make_block('0, 1'b0, commit.itype[i], commit.pc[i], commit.priv, commit.cause, commit.tval);
            push_n = push_n + 1'b1;
          end
          open_d = 1'b0;
          stop   = 1'b1;
        end else if (commit.valid[i]) begin
          sz = commit.compressed[i] ? 2'd1 : 2'd2;
          if (!open_d) begin
            open_d  = 1'b1;
            start_d = commit.pc[i];
            count_d = '0;
            priv_d  = commit.priv;
          end else if ({1'b0, count_d} + (IRETIRE_LEN+1)'(sz) > CNT_MAX) begin
            if (push_n < PN_W'(NPUSH)) begin
              push_blk[push_n] = make_block(count_d, lsize_d, '0, start_d, priv_d, '0, '0);
              push_n = push_n + 1'b1;
            end
            start_d = commit.pc[i];
            count_d = '0;
            priv_d  = commit.priv;
          end
          count_d = count_d + IRETIRE_LEN'(sz);
          lsize_d = !commit.compressed[i];
          if (commit.itype[i] >= ITYPE_LEN'(3)) begin
            if (push_n < PN_W'(NPUSH)) begin
              push_blk[push_n] = make_block(count_d, lsize_d, commit.itype[i], start_d, priv_d, '0, '0);
              push_n = push_n + 1'b1;
            end
            open_d = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    out_n = (occ_q < OCC_W'(N)) ? occ_q : OCC_W'(N);
    pop_n = blocks.ready ? out_n : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q     <= 1'b0;
      count_q    <= '0;
      start_q    <= '0;
      priv_q     <= '0;
      lsize_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        open_q   <= open_d;
        count_q  <= count_d;
        start_q  <= start_d;
        priv_q   <= priv_d;
        lsize_q  <= lsize_d;
        wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
      end else if (in_present) begin
        overflow_q <= 1'b1;
      end
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
      occ_q    <= occ_q + OCC_W'(push_acc) - pop_n;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NPUSH; k++) begin
      if (accept && PN_W'(k) < push_n) mem[wr_ptr_q + PTR_W'(k)] <= push_blk[k];
    end
  end

  // Lanes beyond the occupancy show all-zero fields.
  always_comb begin
    block_t b;
    for (int k = 0; k < N; k++) begin
      b = (OCC_W'(k) < occ_q) ? mem[rd_ptr_q + PTR_W'(k)] : '0;
      blocks.valid[k]     = OCC_W'(k) < occ_q;
      blocks.iretire[k]   = b.iretire;
      blocks.ilastsize[k] = b.ilastsize;
      blocks.itype[k]     = b.itype;
      blocks.iaddr[k]     = b.iaddr;
      blocks.priv[k]      = b.priv;
      blocks.cause[k]     = b.cause;
      blocks.tval[k]      = b.tval;
    end
  end

endmodule

// File: tb/tb_mure_block_packer.sv
// Scoreboard bench for mure_block_packer: expected blocks are queued as stimulus is
// driven and compared against blocks drained from the output lanes.
module tb_mure_block_packer;
  localparam int NRET = 2, N = 2, DEPTH = 8, XLEN = 64;
  localparam int IRETIRE_LEN = 32, ITYPE_LEN = 3, CAUSE_LEN = 8, PRIV_LEN = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } blk_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic overflow_o;
  int   checks = 0;
  int   failures = 0;
  blk_t exp_q[$];
  blk_t got_q[$];

  mure_commit_if #(.NRET(NRET), .XLEN(XLEN), .ITYPE_LEN(ITYPE_LEN), .CAUSE_LEN(CAUSE_LEN),
                   .PRIV_LEN(PRIV_LEN)) cif ();
  mure_block_if #(.N(N), .XLEN(XLEN), .IRETIRE_LEN(IRETIRE_LEN), .ITYPE_LEN(ITYPE_LEN),
                  .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN)) bif ();

  mure_block_packer #(.NRET(NRET), .N(N), .DEPTH(DEPTH), .XLEN(XLEN), .IRETIRE_LEN(IRETIRE_LEN),
                      .ITYPE_LEN(ITYPE_LEN), .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .commit     (cif),
    .blocks     (bif),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic blk_t mk(input int unsigned ir, input logic ls, input int unsigned it,
                              input logic [XLEN-1:0] addr, input int unsigned pv,
                              input int unsigned cs, input logic [XLEN-1:0] tv);
    blk_t b;
    b.iretire   = IRETIRE_LEN'(ir);
    b.ilastsize = ls;
    b.itype     = ITYPE_LEN'(it);
    b.iaddr     = addr;
    b.priv      = PRIV_LEN'(pv);
    b.cause     = CAUSE_LEN'(cs);
    b.tval      = tv;
    return b;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    cif.valid      = '0;
    cif.pc         = '0;
    cif.itype      = '0;
    cif.compressed = '0;
    cif.cause      = '0;
    cif.tval       = '0;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [XLEN-1:0] pc,
                          input int unsigned it, input logic c);
    cif.valid[l]      = v;
    cif.pc[l]         = pc;
    cif.itype[l]      = ITYPE_LEN'(it);
    cif.compressed[l] = c;
  endtask

  // Drains up to n blocks into got_q with ready_i held high; bounded by a cycle budget.
  task automatic collect(input int n);
    blk_t b;
    got_q.delete();
    bif.ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < n; c++) begin
      for (int k = 0; k < N; k++) begin
        if (bif.valid[k]) begin
          b.iretire   = bif.iretire[k];
          b.ilastsize = bif.ilastsize[k];
          b.itype     = bif.itype[k];
          b.iaddr     = bif.iaddr[k];
          b.priv      = bif.priv[k];
          b.cause     = bif.cause[k];
          b.tval      = bif.tval[k];
          got_q.push_back(b);
        end
      end
      step();
    end
    bif.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    cif.priv  = 2'd3;
    bif.ready = 1'b0;
    repeat (3) step();
    checks++; if (bif.valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=00", bif.valid); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow_o); end
    checks++; if (bif.iaddr !== '0) begin failures++; $display("[TB] FAIL reset_iaddr got=%h exp=0", bif.iaddr); end
    rst_ni = 1'b1;
    step();
    checks++; if (cif.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", cif.ready); end
  endtask

  task automatic test_retire_block();
    blk_t g, e;
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      set_lane(0, 1'b1, 64'h1000 + 64'(8 * c), 0, 1'b0);
      set_lane(1, 1'b1, 64'h1004 + 64'(8 * c), 0, 1'b0);
      step();
    end
    clear_inputs();
    checks++; if (bif.valid !== 2'b00) begin failures++; $display("[TB] FAIL open_no_emit got=%b exp=00", bif.valid); end
    set_lane(0, 1'b1, 64'h1018, 3, 1'b0);
    exp_q.push_back(mk(14, 1'b1, 3, 64'h1000, 3, 0, 0));
    step();
    clear_inputs();
    checks++; if (bif.valid !== 2'b01) begin failures++; $display("[TB] FAIL close_latency got=%b exp=01", bif.valid); end
    checks++; if (bif.iaddr[1] !== '0) begin failures++; $display("[TB] FAIL idle_lane_zero got=%h exp=0", bif.iaddr[1]); end
    collect(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL retire_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL retire_block got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_exception();
    blk_t g, e;
    clear_inputs();
    set_lane(0, 1'b1, 64'h2000, 0, 1'b1);
    set_lane(1, 1'b1, 64'h2002, 1, 1'b0);
    cif.cause = 8'd2;
    cif.tval  = 64'hdead;
    exp_q.push_back(mk(1, 1'b0, 1, 64'h2000, 3, 2, 64'hdead));
    step();
    clear_inputs();
    collect(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL exc_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL exc_block got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_interrupt_no_open();
    blk_t g, e;
    clear_inputs();
    set_lane(0, 1'b0, 64'h3000, 2, 1'b0);
    set_lane(1, 1'b1, 64'h3004, 0, 1'b0);
    cif.cause = 8'd5;
    cif.tval  = 64'h77;
    exp_q.push_back(mk(0, 1'b0, 2, 64'h3000, 3, 5, 64'h77));
    step();
    clear_inputs();
    collect(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL irq_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL irq_block got=%h exp=%h", g, e); end
    end
    checks++; if (bif.valid !== 2'b00) begin failures++; $display("[TB] FAIL irq_drained got=%b exp=00", bif.valid); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    blk_t g, e;
    clear_inputs();
    bif.ready = 1'b1;
    set_lane(0, 1'b1, 64'h4000, 4, 1'b0);
    set_lane(1, 1'b1, 64'h4004, 4, 1'b0);
    exp_q.push_back(mk(2, 1'b1, 4, 64'h4000, 3, 0, 0));
    exp_q.push_back(mk(2, 1'b1, 4, 64'h4004, 3, 0, 0));
    step();
    clear_inputs();
    checks++; if (bif.valid !== 2'b11) begin failures++; $display("[TB] FAIL b2b_valid got=%b exp=11", bif.valid); end
    checks++; if (bif.iaddr[0] !== 64'h4000) begin failures++; $display("[TB] FAIL b2b_lane0 got=%h exp=4000", bif.iaddr[0]); end
    collect(2);
    checks++; if (got_q.size() != 2) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL b2b_block got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_full_overflow();
    blk_t g, e;
    bif.ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!cif.ready) break;
      clear_inputs();
      set_lane(0, 1'b1, 64'h8000 + 64'(8 * c), 4, 1'b0);
      set_lane(1, 1'b1, 64'h8004 + 64'(8 * c), 4, 1'b0);
      exp_q.push_back(mk(2, 1'b1, 4, 64'h8000 + 64'(8 * c), 3, 0, 0));
      exp_q.push_back(mk(2, 1'b1, 4, 64'h8004 + 64'(8 * c), 3, 0, 0));
      step();
    end
    clear_inputs();
    checks++; if (exp_q.size() != 6) begin failures++; $display("[TB] FAIL full_pushes got=%0d exp=6", exp_q.size()); end
    checks++; if (cif.ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", cif.ready); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL pre_overflow got=%b exp=0", overflow_o); end
    set_lane(0, 1'b1, 64'h9000, 0, 1'b0);
    step();
    clear_inputs();
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL overflow_set got=%b exp=1", overflow_o); end
    repeat (2) step();
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL overflow_hold got=%b exp=1", overflow_o); end
    collect(6);
    checks++; if (got_q.size() != 6) begin failures++; $display("[TB] FAIL full_count got=%0d exp=6", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL full_block got=%h exp=%h", g, e); end
    end
    checks++; if (overflow_o !== 1'b1 || cif.ready !== 1'b1) begin
      failures++; $display("[TB] FAIL drained_state got=ovf%b/rdy%b exp=ovf1/rdy1", overflow_o, cif.ready);
    end
    exp_q.delete();
  endtask

  task automatic test_priv_change();
    blk_t g, e;
    clear_inputs();
    cif.priv = 2'd3;
    set_lane(0, 1'b1, 64'h5000, 0, 1'b0);
    set_lane(1, 1'b1, 64'h5004, 0, 1'b0);
    step();
    clear_inputs();
    cif.priv = 2'd0;
    set_lane(0, 1'b1, 64'h5008, 0, 1'b0);
    exp_q.push_back(mk(4, 1'b1, 0, 64'h5000, 3, 0, 0));
    step();
    clear_inputs();
    set_lane(0, 1'b1, 64'h500c, 3, 1'b1);
    exp_q.push_back(mk(3, 1'b0, 3, 64'h5008, 0, 0, 0));
    step();
    clear_inputs();
    cif.priv = 2'd3;
    collect(2);
    checks++; if (got_q.size() != 2) begin failures++; $display("[TB] FAIL priv_count got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL priv_block got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    blk_t g, e;
    bif.ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      set_lane(0, 1'b1, 64'h6000 + 64'(8 * c), 4, 1'b0);
      set_lane(1, 1'b1, 64'h6004 + 64'(8 * c), 4, 1'b0);
      step();
    end
    clear_inputs();
    set_lane(0, 1'b1, 64'h6010, 4, 1'b0);
    step();
    clear_inputs();
    set_lane(0, 1'b1, 64'h6100, 0, 1'b0);
    step();
    clear_inputs();
    checks++; if (bif.valid !== 2'b11) begin failures++; $display("[TB] FAIL queued_valid got=%b exp=11", bif.valid); end
    rst_ni = 1'b0;
    #1;
    checks++; if (bif.valid !== 2'b00 || bif.iretire !== '0 || bif.iaddr !== '0 || bif.tval !== '0) begin
      failures++; $display("[TB] FAIL midreset_outputs got=v%b/ir%h/ia%h exp=zero", bif.valid, bif.iretire, bif.iaddr);
    end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL midreset_overflow got=%b exp=0", overflow_o); end
    step();
    rst_ni = 1'b1;
    step();
    checks++; if (cif.ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", cif.ready); end
    set_lane(0, 1'b1, 64'h7000, 0, 1'b0);
    set_lane(1, 1'b1, 64'h7004, 3, 1'b1);
    exp_q.push_back(mk(3, 1'b0, 3, 64'h7000, 3, 0, 0));
    step();
    clear_inputs();
    collect(1);
    checks++; if (got_q.size() != 1) begin failures++; $display("[TB] FAIL post_reset_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL post_reset_block got=%h exp=%h", g, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_retire_block();
    test_exception();
    test_interrupt_no_open();
    test_back_to_back();
    test_full_overflow();
    test_priv_change();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mure_block_packer.md
# mure_block_packer

Parametrised successor to the multiple-retirement front end of the trace encoder. It accepts up to NRET retired instructions per cycle from the commit stage and accumulates consecutive non-discontinuity instructions into E-Trace instruction blocks (iretire, ilastsize, itype, iaddr, priv, cause, tval). It buffers closed blocks in a multi-push FIFO and presents up to N blocks per cycle to the trace encoder over a valid/ready handshake, with backpressure to the commit side.

## Interface
- NRET, 2: commit ports per cycle (1..4)
- N, 2: output block lanes per cycle (1..NRET)
- DEPTH, 8: block FIFO entries; power of two, ≥ 2·NRET
- XLEN, 64: address/tval width
- IRETIRE_LEN, 32; ITYPE_LEN, 3; CAUSE_LEN, 8; PRIV_LEN, 2: field widths per mure_pkg
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  NRET  lane retired an instruction
- pc_i  in  NRET×XLEN  lane instruction address
- itype_i  in  NRET×ITYPE_LEN  lane itype (0 none, 1 exception, 2 interrupt, ≥3 other discontinuity)
- compressed_i  in  NRET  lane instruction is 16-bit
- priv_i  in  PRIV_LEN  privilege for this cycle
- cause_i  in  CAUSE_LEN; tval_i  in  XLEN  exception/interrupt info, valid with itype 1/2
- ready_o  out  1  inputs this cycle are accepted
- valid_o  out  N  output lane k holds a block
- ready_i  in  1  encoder takes all valid lanes this cycle
- iretire_o  out  N×IRETIRE_LEN; ilastsize_o  out  N; itype_o  out  N×ITYPE_LEN; iaddr_o  out  N×XLEN; priv_o  out  N×PRIV_LEN; cause_o  out  N×CAUSE_LEN; tval_o  out  N×XLEN
- overflow_o  out  1  sticky: input presented while ready_o=0

## Operation
- Open-block state: open flag, count (IRETIRE_LEN, half-words), start address, block priv, last size.
- Cycle accepted when ready_o=1. Lanes processed in index order 0..NRET-1; combinational chain updates the open-block state lane by lane.
- Before lane 0: if open and priv_i ≠ block priv, close with itype 0.
- Lane with valid_i=1, itype 0: if not open, open with start=pc, count=0, priv=priv_i. If count + size exceeds 2^IRETIRE_LEN−1, first close with itype 0 and reopen. Then add size (1 compressed, 2 otherwise); last size = !compressed.
- Lane with valid_i=1, itype ≥3: add as above, then close with that itype.
- Lane with itype 1 or 2 (valid_i ignored): close the open block with itype 1/2 and cause_i/tval_i. If no block is open, emit iretire=0, iaddr=pc, ilastsize=0. All higher lanes in that cycle are discarded. Only the lowest such lane counts.
- Closed block: iretire=count, ilastsize=last size, iaddr=start, priv=block priv, cause/tval zero unless itype 1/2.
- Up to NRET+1 closes per cycle; pushed in order into the FIFO.
- Output: lanes 0..min(N,occupancy)−1 show FIFO head onward, oldest on lane 0. valid_o is contiguous from lane 0. When ready_i=1, all valid lanes pop.
- Lanes with valid_o=0 drive all fields zero.
- Cycle not accepted (ready_o=0) with any valid_i or itype 1/2 present: inputs dropped, overflow_o set until reset.

## Timing
- ready_o = (free entries ≥ NRET+1); it is a function of registered occupancy only, with no combinational path from inputs.
- Block closed in cycle t appears on valid_o no earlier than t+1. There is no input-to-output bypass.
- Push and pop in the same cycle are allowed. Occupancy is updated by pushes minus pops. Read/write pointers wrap modulo DEPTH.
- Full FIFO: ready_o=0 and the open-block state holds. Empty FIFO: valid_o=0.
- An open block persists across idle cycles indefinitely and is never flushed by time.
- Reset: asynchronous. FIFO emptied, open flag and count cleared, overflow_o=0, valid_o=0, all output fields 0. After reset release, ready_o=1.

## Test plan
- NRET=2,N=2: 3 cycles, both lanes valid itype 0, pc 0x1000.. (4-byte), then lane0 itype 3 at 0x1018 → one block iretire=14, iaddr=0x1000, ilastsize=1, itype=3, on valid_o[0] one cycle after close.
- Lane0 compressed itype 0 at 0x2000; lane1 itype 1, cause=2, tval=0xdead → block iretire=1, itype=1, cause=2, tval=0xdead, ilastsize=0. Lane1 is not counted.
- Interrupt (itype 2) with no open block, pc=0x3000 → block iretire=0, iaddr=0x3000, itype=2.
- Both lanes itype 4 in one cycle with ready_i=1 → valid_o=2'b11 next cycle, lane0 iaddr=lane0 pc. Hold ready_i=0 until full → ready_o=0. Drive valid_i → overflow_o=1 and sticky.
- priv_i changes 3→0 with an open block of 4 half-words → block closed with itype 0, priv=3, iretire=4. New block opens with priv 0.
- Assert rst_ni mid-stream with 5 blocks queued → all outputs 0 immediately; after release the first block emitted contains only post-reset instructions.
